// File: rtl/counter_timer_pkg.sv
// Shared types for the counter/timer controller: command opcodes, FSM states
// and the run-mode encoding carried in bit 0 of a START command.
package counter_timer_pkg;

  typedef enum logic [1:0] {
    OP_START      = 2'd0,
    OP_STOP       = 2'd1,
    OP_CLEAR      = 2'd2,
    OP_LOAD_LIMIT = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

  // START and LOAD_LIMIT are the only commands refused while counting.
  function automatic logic is_illegal(input op_e op, input state_e st);
    return (st == RUN) && ((op == OP_START) || (op == OP_LOAD_LIMIT));
  endfunction

endpackage

// File: rtl/counter_timer_dp.sv
// Counter datapath: owns the WIDTH-bit count and limit registers and reports
// when the count sits on the limit. All sequencing lives in the controller.
module counter_timer_dp #(
  parameter int WIDTH = 129
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             inc,
  input  logic             reload,
  input  logic             ld_limit,
  input  logic [WIDTH-1:0] limit_data,
  output logic [WIDTH-1:0] count,
  output logic             at_limit
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] limit_q;

  // Carry out of the add is dropped; the only defined wrap is the reload path.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      limit_q <= '1;
    end else begin
      if (clr || reload) begin
        count_q <= '0;
      end else if (inc) begin
        count_q <= count_q + ONE;
      end
      if (ld_limit) begin
        limit_q <= limit_data;
      end
    end
  end

  assign count    = count_q;
  assign at_limit = (count_q == limit_q);

endmodule

// File: rtl/counter_timer_ctrl.sv
// Command-driven interval timer: valid/ready command port, FSM sequencing of
// the counter datapath, and registered expire/err pulse generation.
//
//   state  | meaning
//   IDLE   | stopped after reset or CLEAR, count held
//   RUN    | counting one per cycle toward limit
//   PAUSED | stopped by STOP, count held, resumes on START
//   DONE   | one-shot reached limit, count held at limit
module counter_timer_ctrl
  import counter_timer_pkg::*;
#(
  parameter int WIDTH = 129
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             expire,
  output logic             err
);

  state_e state_q, state_d;
  logic   mode_q, mode_d;
  logic   ready_q;
  logic   expire_q, expire_d;
  logic   err_q, err_d;
  logic   accept;
  op_e    op;

  logic clr, inc, reload, ld_limit;
  logic at_limit;

  assign op     = op_e'(cmd_op);
  assign accept = cmd_valid && ready_q;

  counter_timer_dp #(.WIDTH(WIDTH)) u_dp (
    .clk        (clk),
    .reset      (reset),
    .clr        (clr),
    .inc        (inc),
    .reload     (reload),
    .ld_limit   (ld_limit),
    .limit_data (cmd_data),
    .count      (count),
    .at_limit   (at_limit)
  );

  // An accepted command always wins over the counting step of the same cycle.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    clr      = 1'b0;
    inc      = 1'b0;
    reload   = 1'b0;
    ld_limit = 1'b0;
    expire_d = 1'b0;
    err_d    = accept && is_illegal(op, state_q);

    if (accept) begin
      case (op)
        OP_START: begin
          if (state_q != RUN) begin
            clr     = (state_q == DONE);
            state_d = RUN;
            mode_d  = cmd_data[0];
          end
        end
        OP_STOP: begin
          if (state_q == RUN) state_d = PAUSED;
        end
        OP_CLEAR: begin
          clr     = 1'b1;
          state_d = IDLE;
        end
        OP_LOAD_LIMIT: begin
          ld_limit = (state_q != RUN);
        end
        default: ;
      endcase
    end else if (state_q == RUN) begin
      if (at_limit) begin
        expire_d = 1'b1;
        if (mode_q == MODE_RELOAD) reload  = 1'b1;
        else                       state_d = DONE;
      end else begin
        inc = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      mode_q   <= MODE_ONESHOT;
      ready_q  <= 1'b1;
      expire_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      ready_q  <= !accept;
      expire_q <= expire_d;
      err_q    <= err_d;
    end
  end

  assign cmd_ready = ready_q;
  assign busy      = (state_q == RUN);
  assign expire    = expire_q;
  assign err       = err_q;

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// Self-checking bench for counter_timer_ctrl: directed scenarios on an 8-bit
// instance, randomized traffic against a behavioural model, and a 129-bit instance.
module tb_counter_timer_ctrl;

  localparam int W  = 8;
  localparam int WW = 129;

  localparam logic [1:0] C_START = 2'd0;
  localparam logic [1:0] C_STOP  = 2'd1;
  localparam logic [1:0] C_CLEAR = 2'd2;
  localparam logic [1:0] C_LOAD  = 2'd3;

  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset = 1'b0, cmd_valid = 1'b0, cmd_ready, busy, expire, err;
  logic [1:0]   cmd_op = 2'd0;
  logic [W-1:0] cmd_data = '0, count;

  logic          w_reset = 1'b0, w_valid = 1'b0, w_ready, w_busy, w_expire, w_err;
  logic [1:0]    w_op = 2'd0;
  logic [WW-1:0] w_data = '0, w_count;

  counter_timer_ctrl #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data), .count(count), .busy(busy),
    .expire(expire), .err(err)
  );

  counter_timer_ctrl dut_wide (
    .clk(clk), .reset(w_reset), .cmd_valid(w_valid), .cmd_ready(w_ready),
    .cmd_op(w_op), .cmd_data(w_data), .count(w_count), .busy(w_busy),
    .expire(w_expire), .err(w_err)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural reference for the 8-bit instance, stepped once per clock.
  int           m_st    = M_IDLE;
  logic [W-1:0] m_count = '0, m_limit = '1;
  bit           m_mode = 0, m_exp = 0, m_err = 0, m_ready = 1;

  task automatic model_step();
    bit acc;
    acc = cmd_valid && m_ready;
    if (reset) begin
      m_st = M_IDLE; m_count = '0; m_limit = '1; m_mode = 0;
      m_exp = 0; m_err = 0; m_ready = 1;
      return;
    end
    m_exp = 0; m_err = 0; m_ready = !acc;
    if (acc) begin
      case (cmd_op)
        C_START: begin
          if (m_st == M_RUN) m_err = 1;
          else begin
            if (m_st == M_DONE) m_count = '0;
            m_st = M_RUN; m_mode = cmd_data[0];
          end
        end
        C_STOP:  if (m_st == M_RUN) m_st = M_PAUSED;
        C_CLEAR: begin m_st = M_IDLE; m_count = '0; end
        default: if (m_st == M_RUN) m_err = 1; else m_limit = cmd_data;
      endcase
    end else if (m_st == M_RUN) begin
      if (m_count == m_limit) begin
        m_exp = 1;
        if (m_mode) m_count = '0; else m_st = M_DONE;
      end else begin
        m_count = m_count + 8'd1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic send(input logic [1:0] op, input logic [W-1:0] d);
    if (!m_ready) tick();
    cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    n_checks++; if (count !== 8'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_checks++; if (expire !== 1'b0) begin n_fail++; $display("FAIL reset_expire got %b want 0", expire); end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", cmd_ready); end
  endtask

  task automatic test_reset_mid_run();
    send(C_START, 8'd0);
    idle(37);
    n_checks++; if (count !== 8'd37) begin n_fail++; $display("FAIL midrun_pre got %0d want 37", count); end
    reset = 1'b1; tick(); reset = 1'b0;
    n_checks++; if (count !== 8'd0 || busy !== 1'b0 || cmd_ready !== 1'b1)
      begin n_fail++; $display("FAIL midrun_reset got count=%0d busy=%b ready=%b want 0/0/1", count, busy, cmd_ready); end
    // limit must be back at 255: one-shot expires 257 cycles after START
    send(C_START, 8'd0);
    idle(255);
    n_checks++; if (expire !== 1'b0 || count !== 8'd255) begin n_fail++; $display("FAIL midrun_limit_early got expire=%b count=%0d want 0/255", expire, count); end
    tick();
    n_checks++; if (expire !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL midrun_limit_expire got expire=%b busy=%b want 1/0", expire, busy); end
  endtask

  task automatic test_oneshot();
    send(C_CLEAR, 8'd0);
    send(C_LOAD, 8'd5);
    send(C_START, 8'd0);
    for (int k = 2; k <= 7; k++) begin
      tick();
      n_checks++; if (expire !== (k == 7)) begin n_fail++; $display("FAIL oneshot_expire k=%0d got %b want %b", k, expire, k == 7); end
    end
    n_checks++; if (count !== 8'd5 || busy !== 1'b0) begin n_fail++; $display("FAIL oneshot_done got count=%0d busy=%b want 5/0", count, busy); end
    for (int k = 0; k < 10; k++) begin
      tick();
      n_checks++; if (expire !== 1'b0 || count !== 8'd5) begin n_fail++; $display("FAIL oneshot_hold got expire=%b count=%0d want 0/5", expire, count); end
    end
  endtask

  task automatic test_reload();
    send(C_CLEAR, 8'd0);
    send(C_LOAD, 8'd3);
    send(C_START, 8'd1);
    for (int k = 1; k <= 14; k++) begin
      if (k > 1) tick();
      n_checks++; if (count !== 8'((k - 1) % 4) || expire !== (k >= 5 && (k - 5) % 4 == 0))
        begin n_fail++; $display("FAIL reload3 k=%0d got count=%0d expire=%b want %0d/%b", k, count, expire, (k - 1) % 4, (k >= 5 && (k - 5) % 4 == 0)); end
    end
    send(C_CLEAR, 8'd0);
    send(C_LOAD, 8'd0);
    send(C_START, 8'd1);
    for (int k = 1; k <= 6; k++) begin
      if (k > 1) tick();
      n_checks++; if (count !== 8'd0 || expire !== (k >= 2) || busy !== 1'b1)
        begin n_fail++; $display("FAIL reload0 k=%0d got count=%0d expire=%b busy=%b want 0/%b/1", k, count, expire, busy, k >= 2); end
    end
  endtask

  task automatic test_stop_resume();
    send(C_CLEAR, 8'd0);
    send(C_STOP, 8'd0);
    n_checks++; if (err !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL stop_idle got err=%b busy=%b want 0/0", err, busy); end
    send(C_LOAD, 8'd255);
    send(C_START, 8'd0);
    idle(10);
    send(C_STOP, 8'd0);
    n_checks++; if (count !== 8'd10 || busy !== 1'b0) begin n_fail++; $display("FAIL stop_pause got count=%0d busy=%b want 10/0", count, busy); end
    idle(3);
    n_checks++; if (count !== 8'd10) begin n_fail++; $display("FAIL stop_hold got %0d want 10", count); end
    send(C_START, 8'd0);
    n_checks++; if (count !== 8'd10 || busy !== 1'b1) begin n_fail++; $display("FAIL resume got count=%0d busy=%b want 10/1", count, busy); end
    tick();
    send(C_START, 8'd0);
    n_checks++; if (err !== 1'b1 || count !== 8'd11 || busy !== 1'b1) begin n_fail++; $display("FAIL start_in_run got err=%b count=%0d busy=%b want 1/11/1", err, count, busy); end
    tick();
    n_checks++; if (err !== 1'b0 || count !== 8'd12) begin n_fail++; $display("FAIL err_pulse got err=%b count=%0d want 0/12", err, count); end
  endtask

  task automatic test_collision();
    int first;
    send(C_CLEAR, 8'd0);
    send(C_LOAD, 8'd4);
    send(C_START, 8'd0);
    idle(4);
    send(C_STOP, 8'd0);
    n_checks++; if (count !== 8'd4 || busy !== 1'b0 || expire !== 1'b0) begin n_fail++; $display("FAIL collide_stop got count=%0d busy=%b expire=%b want 4/0/0", count, busy, expire); end
    tick();
    n_checks++; if (expire !== 1'b0) begin n_fail++; $display("FAIL collide_late_expire got %b want 0", expire); end
    send(C_CLEAR, 8'd0);
    send(C_LOAD, 8'd6);
    send(C_START, 8'd0);
    send(C_LOAD, 8'd2);
    n_checks++; if (err !== 1'b1 || count !== 8'd1) begin n_fail++; $display("FAIL load_in_run got err=%b count=%0d want 1/1", err, count); end
    first = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (expire === 1'b1 && first == 0) first = i;
    end
    n_checks++; if (first != 6 || count !== 8'd6) begin n_fail++; $display("FAIL limit_kept got expire_at=%0d count=%0d want 6/6", first, count); end
  endtask

  task automatic test_wrap();
    int first;
    send(C_CLEAR, 8'd0);
    send(C_LOAD, 8'd255);
    send(C_START, 8'd1);
    idle(254);
    send(C_STOP, 8'd0);
    send(C_START, 8'd1);
    n_checks++; if (count !== 8'd254) begin n_fail++; $display("FAIL wrap_pre got %0d want 254", count); end
    tick();
    n_checks++; if (count !== 8'd255 || expire !== 1'b0) begin n_fail++; $display("FAIL wrap_top got count=%0d expire=%b want 255/0", count, expire); end
    tick();
    n_checks++; if (count !== 8'd0 || expire !== 1'b1) begin n_fail++; $display("FAIL wrap_zero got count=%0d expire=%b want 0/1", count, expire); end
    tick();
    n_checks++; if (count !== 8'd1 || expire !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL wrap_after got count=%0d expire=%b busy=%b want 1/0/1", count, expire, busy); end
    // limit below a paused count: runs through the wrap to reach it
    send(C_CLEAR, 8'd0);
    send(C_START, 8'd0);
    idle(5);
    send(C_STOP, 8'd0);
    send(C_LOAD, 8'd2);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL low_limit_err got %b want 0", err); end
    send(C_START, 8'd1);
    first = 0;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (expire === 1'b1 && first == 0) first = i;
    end
    n_checks++; if (first != 254) begin n_fail++; $display("FAIL low_limit_wrap got expire_at=%0d want 254", first); end
  endtask

  task automatic test_back_to_back();
    send(C_CLEAR, 8'd0);
    tick();
    n_checks++; if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_start got %b want 1", cmd_ready); end
    cmd_valid = 1'b1; cmd_op = C_STOP; cmd_data = '0;
    for (int i = 1; i <= 6; i++) begin
      tick();
      n_checks++; if (cmd_ready !== (i % 2 == 0)) begin n_fail++; $display("FAIL b2b_ready i=%0d got %b want %b", i, cmd_ready, i % 2 == 0); end
    end
    cmd_valid = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      reset     = ($urandom_range(0, 99) == 0);
      cmd_valid = ($urandom_range(0, 1) == 1);
      cmd_op    = 2'($urandom_range(0, 3));
      cmd_data  = (cmd_op == C_LOAD) ? 8'($urandom_range(0, 20)) : 8'($urandom);
      tick();
      n_checks++;
      if (count !== m_count || busy !== (m_st == M_RUN) || expire !== m_exp || err !== m_err || cmd_ready !== m_ready)
        begin n_fail++; $display("FAIL random i=%0d got c=%0d b=%b x=%b e=%b r=%b want c=%0d b=%b x=%b e=%b r=%b",
                                 i, count, busy, expire, err, cmd_ready, m_count, m_st == M_RUN, m_exp, m_err, m_ready); end
    end
    reset = 1'b0; cmd_valid = 1'b0;
  endtask

  task automatic wsend(input logic [1:0] op, input logic [WW-1:0] d);
    w_valid = 1'b1; w_op = op; w_data = d;
    tick();
    w_valid = 1'b0;
    tick();
  endtask

  task automatic test_wide();
    logic [WW-1:0] big;
    w_reset = 1'b1; tick(); w_reset = 1'b0;
    n_checks++; if (w_count !== '0 || w_busy !== 1'b0 || w_ready !== 1'b1) begin n_fail++; $display("FAIL wide_reset got count=%0h busy=%b ready=%b want 0/0/1", w_count, w_busy, w_ready); end
    big = '0; big[WW-1] = 1'b1; big[1:0] = 2'd3;
    wsend(C_LOAD, big);
    w_valid = 1'b1; w_op = C_START; w_data = '0; tick(); w_valid = 1'b0;
    idle(5);
    n_checks++; if (w_count !== WW'(5) || w_expire !== 1'b0 || w_busy !== 1'b1) begin n_fail++; $display("FAIL wide_count got count=%0h expire=%b busy=%b want 5/0/1", w_count, w_expire, w_busy); end
    wsend(C_CLEAR, '0);
    wsend(C_LOAD, WW'(2));
    w_valid = 1'b1; w_op = C_START; w_data = WW'(1); tick(); w_valid = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      if (k > 1) tick();
      n_checks++; if (w_count !== WW'((k - 1) % 3) || w_expire !== (k >= 4 && (k - 4) % 3 == 0))
        begin n_fail++; $display("FAIL wide_reload k=%0d got count=%0h expire=%b want %0d/%b", k, w_count, w_expire, (k - 1) % 3, (k >= 4 && (k - 4) % 3 == 0)); end
    end
  endtask

  initial begin
    test_reset();
    test_reset_mid_run();
    test_oneshot();
    test_reload();
    test_stop_resume();
    test_collision();
    test_wrap();
    test_back_to_back();
    test_random();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
